// File: rtl/pm_entry_pkg.sv
// Shared definitions for the PM-entry wrapper: sideband message codes, the
// responder state encoding and the default 2 us timeout counts.
package pm_entry_pkg;

  // Sideband LinkMgmt.RDI message codes
  localparam logic [3:0] MsgReqL1     = 4'd2;
  localparam logic [3:0] MsgReqL2     = 4'd3;
  localparam logic [3:0] MsgRspPmnak  = 4'd9;
  localparam logic [3:0] MsgRspL1     = 4'd10;
  localparam logic [3:0] MsgRspL2     = 4'd11;

  // 2 us expressed in clock cycles for each supported clock rate
  localparam int unsigned Cnt100MhzDefault = 200;
  localparam int unsigned Cnt200MhzDefault = 400;
  localparam int unsigned TimeoutCntW      = 9;

  typedef enum logic [2:0] {
    StIdle,
    StWaitReq,
    StDecide,
    StSendResp,
    StDone
  } rx_state_e;

endpackage

// File: rtl/pm_timeout_cnt.sv
// Saturating 2 us timeout counter with clock-rate dependent limit.
// Shared between the PM-entry responder and transmitter.
module pm_timeout_cnt
  import pm_entry_pkg::*;
#(
  parameter int unsigned CNT_100MHZ = Cnt100MhzDefault,
  parameter int unsigned CNT_200MHZ = Cnt200MhzDefault
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_run,
  input  logic i_clk_div_ratio,
  output logic o_expired
);

  localparam logic [TimeoutCntW-1:0] Lim100 = CNT_100MHZ[TimeoutCntW-1:0];
  localparam logic [TimeoutCntW-1:0] Lim200 = CNT_200MHZ[TimeoutCntW-1:0];

  logic [TimeoutCntW-1:0] cnt_q, cnt_d;
  logic [TimeoutCntW-1:0] limit;

  assign limit     = i_clk_div_ratio ? Lim200 : Lim100;
  assign o_expired = (cnt_q == limit);

  // Count while running, hold at the limit, clear on request
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_run && (cnt_q != limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pm_entry_rx.sv
// Responder side of the RDI PM-entry handshake: catches a remote Req.L1/L2,
// waits for the local accept/reject, then sends Rsp.L1/Rsp.L2/PMNAK.
// Optional feature macro PM_ENTRY_RX_TIMEOUT_EN forces a PMNAK when no decision
// arrives within 2 us.
module pm_entry_rx
  import pm_entry_pkg::*;
#(
  parameter int unsigned CNT_100MHZ = Cnt100MhzDefault,
  parameter int unsigned CNT_200MHZ = Cnt200MhzDefault
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_clk_div_ratio,
  input  logic       i_accept,
  input  logic       i_reject,
  input  logic       i_tx_msg_valid,
  input  logic       i_msg_valid,
  input  logic [3:0] i_msg_no,
  input  logic       i_msg_done,
  output logic       o_msg_valid,
  output logic [3:0] o_msg_no,
  output logic       o_rx_msg_valid,
  output logic       o_req_valid,
  output logic       o_req_is_l2,
  output logic       o_resp_done,
  output logic       o_pm_nak
);

  rx_state_e  state_q, state_d;
  logic       is_l2_q, is_l2_d;
  logic       dec_valid_q, dec_valid_d;
  logic       dec_nak_q, dec_nak_d;
  logic [3:0] code_q, code_d;

  logic       msg_valid_q, msg_valid_d;
  logic [3:0] msg_no_q, msg_no_d;
  logic       rx_msg_valid_q, rx_msg_valid_d;
  logic       req_valid_q, req_valid_d;
  logic       req_is_l2_q, req_is_l2_d;
  logic       resp_done_q, resp_done_d;
  logic       pm_nak_q, pm_nak_d;

  logic       timeout;

`ifdef PM_ENTRY_RX_TIMEOUT_EN
  logic timeout_raw;

  pm_timeout_cnt #(
    .CNT_100MHZ (CNT_100MHZ),
    .CNT_200MHZ (CNT_200MHZ)
  ) u_timeout (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clr           (!i_en || (state_q != StDecide)),
    .i_run           (state_q == StDecide),
    .i_clk_div_ratio (i_clk_div_ratio),
    .o_expired       (timeout_raw)
  );

  assign timeout = timeout_raw && (state_q == StDecide);
`else
  logic unused_cfg;
  assign unused_cfg = ^{i_clk_div_ratio, CNT_100MHZ[0], CNT_200MHZ[0]};
  assign timeout    = 1'b0;
`endif

  // Next-state and decision latch; the first decision in DECIDE is held while
  // the transmitter still owns the port
  always_comb begin
    state_d     = state_q;
    is_l2_d     = is_l2_q;
    dec_valid_d = dec_valid_q;
    dec_nak_d   = dec_nak_q;
    code_d      = code_q;
    case (state_q)
      StIdle: begin
        is_l2_d     = 1'b0;
        dec_valid_d = 1'b0;
        dec_nak_d   = 1'b0;
        code_d      = '0;
        if (i_en) state_d = StWaitReq;
      end
      StWaitReq: begin
        if (i_msg_valid && ((i_msg_no == MsgReqL1) || (i_msg_no == MsgReqL2))) begin
          is_l2_d = (i_msg_no == MsgReqL2);
          state_d = StDecide;
        end
      end
      StDecide: begin
        if (!dec_valid_q) begin
          if (i_reject || timeout) begin
            dec_valid_d = 1'b1;
            dec_nak_d   = 1'b1;
            code_d      = MsgRspPmnak;
          end else if (i_accept) begin
            dec_valid_d = 1'b1;
            dec_nak_d   = 1'b0;
            code_d      = is_l2_q ? MsgRspL2 : MsgRspL1;
          end
        end
        if (dec_valid_d && !i_tx_msg_valid) state_d = StSendResp;
      end
      StSendResp: begin
        if (i_msg_done) state_d = StDone;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (!i_en) state_d = StIdle;
  end

  // Output next values decoded from the current state; i_en low clears them at once
  always_comb begin
    msg_valid_d    = i_en && (state_q == StSendResp);
    msg_no_d       = (i_en && ((state_q == StSendResp) || (state_q == StDone))) ? code_q : '0;
    rx_msg_valid_d = i_en && ((state_q == StDecide) || (state_q == StSendResp));
    req_valid_d    = i_en && (state_q == StDecide);
    req_is_l2_d    = i_en && is_l2_q &&
                     ((state_q == StDecide) || (state_q == StSendResp) || (state_q == StDone));
    resp_done_d    = i_en && (state_q == StDone);
    pm_nak_d       = i_en && (state_q == StDone) && dec_nak_q;
  end

  // State, decision and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      is_l2_q        <= 1'b0;
      dec_valid_q    <= 1'b0;
      dec_nak_q      <= 1'b0;
      code_q         <= '0;
      msg_valid_q    <= 1'b0;
      msg_no_q       <= '0;
      rx_msg_valid_q <= 1'b0;
      req_valid_q    <= 1'b0;
      req_is_l2_q    <= 1'b0;
      resp_done_q    <= 1'b0;
      pm_nak_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_l2_q        <= is_l2_d;
      dec_valid_q    <= dec_valid_d;
      dec_nak_q      <= dec_nak_d;
      code_q         <= code_d;
      msg_valid_q    <= msg_valid_d;
      msg_no_q       <= msg_no_d;
      rx_msg_valid_q <= rx_msg_valid_d;
      req_valid_q    <= req_valid_d;
      req_is_l2_q    <= req_is_l2_d;
      resp_done_q    <= resp_done_d;
      pm_nak_q       <= pm_nak_d;
    end
  end

  assign o_msg_valid    = msg_valid_q;
  assign o_msg_no       = msg_no_q;
  assign o_rx_msg_valid = rx_msg_valid_q;
  assign o_req_valid    = req_valid_q;
  assign o_req_is_l2    = req_is_l2_q;
  assign o_resp_done    = resp_done_q;
  assign o_pm_nak       = pm_nak_q;

endmodule

// File: tb/tb_pm_entry_rx.sv
// Directed self-checking bench for pm_entry_rx.
module tb_pm_entry_rx;

  logic       clk = 1'b0;
  logic       rst, en, div, accept, reject, txv, mv, mdone;
  logic [3:0] mno;
  logic       o_msg_valid, o_rx_msg_valid, o_req_valid, o_req_is_l2, o_resp_done, o_pm_nak;
  logic [3:0] o_msg_no;

  int checks   = 0;
  int failures = 0;

  pm_entry_rx dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_en            (en),
    .i_clk_div_ratio (div),
    .i_accept        (accept),
    .i_reject        (reject),
    .i_tx_msg_valid  (txv),
    .i_msg_valid     (mv),
    .i_msg_no        (mno),
    .i_msg_done      (mdone),
    .o_msg_valid     (o_msg_valid),
    .o_msg_no        (o_msg_no),
    .o_rx_msg_valid  (o_rx_msg_valid),
    .o_req_valid     (o_req_valid),
    .o_req_is_l2     (o_req_is_l2),
    .o_resp_done     (o_resp_done),
    .o_pm_nak        (o_pm_nak)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: {msg_valid, msg_no, rx_msg_valid, req_valid, is_l2, done, nak}
  logic [31:0] outs;
  assign outs = {22'd0, o_msg_valid, o_msg_no, o_rx_msg_valid, o_req_valid, o_req_is_l2,
                 o_resp_done, o_pm_nak};

  function automatic logic [31:0] ev(input logic v, input logic [3:0] no, input logic rx,
                                     input logic rq, input logic l2, input logic dn,
                                     input logic nk);
    return {22'd0, v, no, rx, rq, l2, dn, nk};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sideband message for a single sampling edge
  task automatic send_msg(input logic [3:0] code);
    mv  = 1'b1;
    mno = code;
    step();
    mv  = 1'b0;
    mno = 4'd0;
  endtask

  task automatic pulse_done();
    mdone = 1'b1;
    step();
    mdone = 1'b0;
  endtask

  // Pass through IDLE and come back waiting for a request
  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    logic seen;
    rst = 1'b1; en = 1'b0; div = 1'b0; accept = 1'b0; reject = 1'b0;
    txv = 1'b0; mv = 1'b0; mno = 4'd0; mdone = 1'b0;
    step(); step();
    check("reset", outs, 32'd0);
    rst = 1'b0;
    step();
    check("idle_no_en", outs, 32'd0);
    en = 1'b1;
    step();
    check("wait_req", outs, 32'd0);

    // Accept L1
    send_msg(4'd2);
    step();
    check("l1_decide", outs, ev(0, 0, 1, 1, 0, 0, 0));
    accept = 1'b1;
    step();
    accept = 1'b0;
    check("l1_accept_lat", outs, ev(0, 0, 1, 1, 0, 0, 0));
    step();
    check("l1_send", outs, ev(1, 10, 1, 0, 0, 0, 0));
    step(); step(); step();
    pulse_done();
    step();
    check("l1_done", outs, ev(0, 10, 0, 0, 0, 1, 0));
    en = 1'b0;
    step();
    check("en_drop", outs, 32'd0);
    en = 1'b1;
    step();

    // Stray codes in WAIT_REQ
    send_msg(4'd10);
    step();
    check("stray10", outs, 32'd0);
    send_msg(4'd9);
    step();
    check("stray9", outs, 32'd0);

    // Reject L2
    send_msg(4'd3);
    step();
    check("l2_decide", outs, ev(0, 0, 1, 1, 1, 0, 0));
    reject = 1'b1;
    step();
    reject = 1'b0;
    step();
    check("l2_send", outs, ev(1, 9, 1, 0, 1, 0, 0));
    pulse_done();
    step();
    check("l2_done", outs, ev(0, 9, 0, 0, 1, 1, 1));
    send_msg(4'd2);
    step();
    check("done_ignores_req", outs, ev(0, 9, 0, 0, 1, 1, 1));

    // Simultaneous accept and reject
    restart();
    send_msg(4'd2);
    step();
    accept = 1'b1; reject = 1'b1;
    step();
    accept = 1'b0; reject = 1'b0;
    step();
    check("both_nak", outs, ev(1, 9, 1, 0, 0, 0, 0));
    pulse_done();
    step();
    check("both_done", outs, ev(0, 9, 0, 0, 0, 1, 1));

    // Port contention: decision held while transmitter owns the port
    restart();
    send_msg(4'd3);
    step();
    txv = 1'b1; accept = 1'b1;
    step();
    accept = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mdone = (i == 4);
      step();
    end
    mdone = 1'b0;
    check("cont_hold", outs, ev(0, 0, 1, 1, 1, 0, 0));
    txv = 1'b0;
    step();
    check("cont_release", outs, ev(0, 0, 1, 1, 1, 0, 0));
    step();
    check("cont_send", outs, ev(1, 11, 1, 0, 1, 0, 0));

    // Abort in SEND_RESP, then a normal transaction
    en = 1'b0;
    step();
    check("abort_send", outs, 32'd0);
    en = 1'b1;
    step();
    send_msg(4'd2);
    step();
    accept = 1'b1;
    step();
    accept = 1'b0;
    step();
    check("reen_send", outs, ev(1, 10, 1, 0, 0, 0, 0));
    pulse_done();
    step();
    check("reen_done", outs, ev(0, 10, 0, 0, 0, 1, 0));

    // Reset in DECIDE
    restart();
    send_msg(4'd2);
    step();
    check("rst_pre", outs, ev(0, 0, 1, 1, 0, 0, 0));
    rst = 1'b1;
    step();
    check("rst_mid", outs, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst", outs, 32'd0);

`ifdef PM_ENTRY_RX_TIMEOUT_EN
    // 100 MHz: counter hits 200, PMNAK forced, o_msg_valid two edges later
    div = 1'b0;
    send_msg(4'd2);
    n = 0;
    while (!o_msg_valid && n < 1000) begin
      step();
      n++;
    end
    check("to100_lat", n, 202);
    check("to100_code", outs, ev(1, 9, 1, 0, 0, 0, 0));
    pulse_done();
    step();
    check("to100_done", outs, ev(0, 9, 0, 0, 0, 1, 1));
    restart();
    div = 1'b1;
    send_msg(4'd3);
    n = 0;
    while (!o_msg_valid && n < 1000) begin
      step();
      n++;
    end
    check("to200_lat", n, 402);
    check("to200_code", outs, ev(1, 9, 1, 0, 1, 0, 0));
`else
    send_msg(4'd2);
    seen = 1'b0;
    repeat (1000) begin
      step();
      if (o_msg_valid) seen = 1'b1;
    end
    check("no_timeout", {31'd0, seen}, 32'd0);
    check("still_decide", outs, ev(0, 0, 1, 1, 0, 0, 0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
